// File: rtl/input_packet_buffer.sv
// Store-and-forward packet buffer: commits good frames, drops errored/oversized/overflowing frames.
// Latency: first word on m_axis 2 cycles after the committing tlast beat (RAM read + output register).
// Backpressure: never stalls s_axis; m_axis holds while tvalid && !tready. Stats under INPUT_PACKET_BUFFER_STATS_EN.
module input_packet_buffer #(
   parameter int DEPTH_LOG2    = 6,
   parameter int MAX_PKT_WORDS = 48
) (
   input  logic         axi_aclk,
   input  logic         axi_resetn,
   input  logic [255:0] s_axis_tdata,
   input  logic [31:0]  s_axis_tkeep,
   input  logic [0:0]   s_axis_tuser,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic         s_axis_tlast,
   output logic [255:0] m_axis_tdata,
   output logic [31:0]  m_axis_tkeep,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic [31:0]  drop_err_cnt,
   output logic [31:0]  drop_ovf_cnt
);
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int EW    = 256 + 32 + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef enum logic {ACCEPT = 1'b0, DROP = 1'b1} wr_state_t;

   // Entry layout: {last, keep, data}
   logic [EW-1:0] mem [DEPTH];

   // wr_ptr: next free entry; cm_ptr: end of committed data;
   // fe_ptr: next committed entry to fetch from RAM; rd_ptr: oldest entry not yet handed off on m_axis.
   // Words sitting in the read pipeline still count as occupied until their m_axis handshake.
   ptr_t          wr_ptr, cm_ptr, rd_ptr, fe_ptr;
   ptr_t          wr_ptr_nxt, cm_ptr_nxt;
   ptr_t          occupancy, pkt_words;
   wr_state_t     state, state_nxt;
   logic          beat, full, too_long;
   logic          mem_we, cnt_err, cnt_ovf;
   logic          out_free, fetch, s1_vld;
   logic [EW-1:0] s1_dat;

   assign beat      = s_axis_tvalid & s_axis_tready;
   assign occupancy = wr_ptr - rd_ptr;
   assign full      = (occupancy == ptr_t'(DEPTH));
   // In ACCEPT, words of the packet in progress are exactly those between cm_ptr and wr_ptr
   assign pkt_words = wr_ptr - cm_ptr;
   assign too_long  = (32'(pkt_words) + 32'd1) > 32'(MAX_PKT_WORDS);

   // Write FSM: decide per beat whether to store, commit, rewind or discard
   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      cm_ptr_nxt = cm_ptr;
      mem_we     = 1'b0;
      cnt_err    = 1'b0;
      cnt_ovf    = 1'b0;
      case (state)
         ACCEPT: begin
            if (beat) begin
               if (full || too_long) begin
                  // Rewind the partial packet; a tlast beat closes the frame right here
                  wr_ptr_nxt = cm_ptr;
                  if (s_axis_tlast) begin
                     cnt_ovf = 1'b1;
                  end else begin
                     state_nxt = DROP;
                  end
               end else if (s_axis_tlast && s_axis_tuser[0]) begin
                  wr_ptr_nxt = cm_ptr;
                  cnt_err    = 1'b1;
               end else begin
                  mem_we     = 1'b1;
                  wr_ptr_nxt = wr_ptr + ptr_t'(1);
                  if (s_axis_tlast) begin
                     cm_ptr_nxt = wr_ptr + ptr_t'(1);
                  end
               end
            end
         end
         DROP: begin
            if (beat && s_axis_tlast) begin
               cnt_ovf   = 1'b1;
               state_nxt = ACCEPT;
            end
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   // Write FSM state register
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state <= ACCEPT;
      end else begin
         state <= state_nxt;
      end
   end

   // Pointers and input ready; ready rises on the first edge after reset release
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr        <= '0;
         cm_ptr        <= '0;
         rd_ptr        <= '0;
         fe_ptr        <= '0;
         s_axis_tready <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr_nxt;
         cm_ptr        <= cm_ptr_nxt;
         s_axis_tready <= 1'b1;
         if (fetch) begin
            fe_ptr <= fe_ptr + ptr_t'(1);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
         end
      end
   end

   // Buffer RAM write port
   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      end
   end

   // Fetch only committed words, and only when the pipeline can take one more
   assign out_free = ~m_axis_tvalid | m_axis_tready;
   assign fetch    = (fe_ptr != cm_ptr) & (~s1_vld | out_free);

   // Registered RAM read port; holds its word while the output stage is stalled
   always_ff @(posedge axi_aclk) begin
      if (fetch) begin
         s1_dat <= mem[fe_ptr[DEPTH_LOG2-1:0]];
      end
   end

   // Read-stage valid and the one-entry output register
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         s1_vld        <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tkeep  <= '0;
         m_axis_tdata  <= '0;
      end else begin
         if (fetch) begin
            s1_vld <= 1'b1;
         end else if (out_free) begin
            s1_vld <= 1'b0;
         end
         if (out_free) begin
            m_axis_tvalid <= s1_vld;
            if (s1_vld) begin
               {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= s1_dat;
            end
         end
      end
   end

`ifdef INPUT_PACKET_BUFFER_STATS_EN
   // Saturating drop statistics
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         drop_err_cnt <= '0;
         drop_ovf_cnt <= '0;
      end else begin
         if (cnt_err && (drop_err_cnt != 32'hFFFF_FFFF)) begin
            drop_err_cnt <= drop_err_cnt + 32'd1;
         end
         if (cnt_ovf && (drop_ovf_cnt != 32'hFFFF_FFFF)) begin
            drop_ovf_cnt <= drop_ovf_cnt + 32'd1;
         end
      end
   end
`else
   // Statistics compiled out: ports stay, values are constant
   logic unused_cnt;
   assign unused_cnt   = cnt_err ^ cnt_ovf;
   assign drop_err_cnt = '0;
   assign drop_ovf_cnt = '0;
`endif

endmodule
